// File: rtl/divider_pkg.sv
// Shared definitions for the sequential signed divider: state encoding and
// default operand width.
package divider_pkg;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_CALC = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;
    localparam logic [1:0] DIV_DONE = 2'd3;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = DIV_IDLE,
        S_CALC = DIV_CALC,
        S_FIX  = DIV_FIX,
        S_DONE = DIV_DONE
    } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring shift-and-subtract iteration on unsigned magnitudes,
// WIDTH+1 bits wide so that |-2^(WIDTH-1)| is representable.
module div_restore_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] i_rem,   // partial remainder before the shift
    input  logic           i_bit,   // next dividend bit shifted in
    input  logic [WIDTH:0] i_dvs,   // divisor magnitude
    output logic [WIDTH:0] o_rem,   // partial remainder after the step
    output logic           o_qbit   // quotient bit produced by this step
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // Shift in the next dividend bit and keep the trial difference only if
    // it did not go negative. The shifted value stays below 2^WIDTH, so the
    // sign of the WIDTH+1 bit difference is exact.
    always_comb begin
        w_shift = (i_rem << 1) | {{WIDTH{1'b0}}, i_bit};
        w_trial = w_shift - i_dvs;
        o_qbit  = ~w_trial[WIDTH];
        o_rem   = o_qbit ? w_trial : w_shift;
    end

endmodule

// File: rtl/signed_seq_divider.sv
// Sequential two's-complement divider, truncating toward zero, one restoring
// step per cycle, valid/ready on both sides with one division in flight.
module signed_seq_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_t       r_state, w_next;

    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;      // operand signs differ
    logic             r_neg_r;      // dividend negative
    logic             r_ovf_pend;   // -2^(W-1) / -1 seen at accept
    logic [WIDTH:0]   r_rem;        // partial remainder magnitude
    logic [WIDTH-1:0] r_quo;        // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH:0]   r_dvs;        // divisor magnitude

    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remd;
    logic             r_dbz;
    logic             r_ovf;

    logic [WIDTH:0]   w_dvs_ext;
    logic [WIDTH:0]   w_dvs_mag;
    logic [WIDTH-1:0] w_dvd_mag;
    logic             w_dvs_zero;
    logic             w_is_ovf;
    logic [WIDTH:0]   w_step_rem;
    logic             w_qbit;

    // Operand magnitudes. The dividend magnitude is held unsigned in WIDTH
    // bits, which is exact for -2^(WIDTH-1) as well (1000..0).
    always_comb begin
        w_dvs_ext  = {divisor[WIDTH-1], divisor};
        w_dvs_mag  = divisor[WIDTH-1] ? (~w_dvs_ext + 1'b1) : w_dvs_ext;
        w_dvd_mag  = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        w_dvs_zero = (divisor == '0);
        w_is_ovf   = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    end

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_quo[WIDTH-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_step_rem),
        .o_qbit (w_qbit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = w_dvs_zero ? S_DONE : S_CALC;
            end
            S_CALC: if (r_cnt == LAST_STEP) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_quot     <= '0;
            r_remd     <= '0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    if (w_dvs_zero) begin
                        r_quot <= '1;
                        r_remd <= dividend;
                        r_dbz  <= 1'b1;
                        r_ovf  <= 1'b0;
                    end else begin
                        r_neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg_r    <= dividend[WIDTH-1];
                        r_ovf_pend <= w_is_ovf;
                        r_quo      <= w_dvd_mag;
                        r_dvs      <= w_dvs_mag;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                    end
                end
                S_CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    // Overflow needs no special case: the magnitude 10..0
                    // left un-negated already reads as -2^(WIDTH-1).
                    r_quot <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
                    r_remd <= r_neg_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
                    r_dbz  <= 1'b0;
                    r_ovf  <= r_ovf_pend;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_remd;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed and exhaustive checks of signed_seq_divider at WIDTH=4.
module tb_signed_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready, out_valid, div_by_zero, overflow;
    logic [W-1:0] quotient, remainder;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        int         a;
        int         b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        logic       ovf;
    } vec_t;

    vec_t vt[14];

    signed_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Present one operand pair, wait for the result, capture it on the
    // handshake cycle and complete the handshake.
    task automatic run_div(input int a, input int b,
                           output logic [3:0] q, output logic [3:0] r,
                           output logic dbz, output logic ovf, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready wait", 32'd0, 32'd1);
        dividend = 4'(a);
        divisor  = 4'(b);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) check("out_valid wait", 32'd0, 32'd1);
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
        ovf = overflow;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] q, r, tq, tr;
        logic       dbz, ovf;
        int         lat, eq, er, guard;

        vt[0]  = '{ 7,  2, 4'b0011, 4'b0001, 1'b0, 1'b0};
        vt[1]  = '{-7,  2, 4'b1101, 4'b1111, 1'b0, 1'b0};
        vt[2]  = '{ 7, -2, 4'b1101, 4'b0001, 1'b0, 1'b0};
        vt[3]  = '{-8, -1, 4'b1000, 4'b0000, 1'b0, 1'b1};
        vt[4]  = '{-8,  1, 4'b1000, 4'b0000, 1'b0, 1'b0};
        vt[5]  = '{ 5,  0, 4'b1111, 4'b0101, 1'b1, 1'b0};
        vt[6]  = '{-8,  0, 4'b1111, 4'b1000, 1'b1, 1'b0};
        vt[7]  = '{ 0,  5, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vt[8]  = '{-8,  7, 4'b1111, 4'b1111, 1'b0, 1'b0};
        vt[9]  = '{ 7,  7, 4'b0001, 4'b0000, 1'b0, 1'b0};
        vt[10] = '{-1, -8, 4'b0000, 4'b1111, 1'b0, 1'b0};
        vt[11] = '{-8, -8, 4'b0001, 4'b0000, 1'b0, 1'b0};
        vt[12] = '{ 3, -8, 4'b0000, 4'b0011, 1'b0, 1'b0};
        vt[13] = '{-6, -4, 4'b0001, 4'b1110, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready",  32'(in_ready),    32'd1);
        check("rst out_valid", 32'(out_valid),   32'd0);
        check("rst quotient",  32'(quotient),    32'd0);
        check("rst remainder", 32'(remainder),   32'd0);
        check("rst dbz",       32'(div_by_zero), 32'd0);
        check("rst ovf",       32'(overflow),    32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            run_div(vt[i].a, vt[i].b, q, r, dbz, ovf, lat);
            check($sformatf("vec%0d q", i),   32'(q),   32'(vt[i].q));
            check($sformatf("vec%0d r", i),   32'(r),   32'(vt[i].r));
            check($sformatf("vec%0d dbz", i), 32'(dbz), 32'(vt[i].dbz));
            check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vt[i].ovf));
            check($sformatf("vec%0d latency", i), 32'(lat), vt[i].dbz ? 32'd1 : 32'd6);
        end

        // Backpressure: result held for 3 cycles, stray in_valid ignored
        @(negedge clk);
        dividend = 4'd7;
        divisor  = 4'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        guard = 1;
        while (!out_valid && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("bp latency", 32'(guard), 32'd6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = (i == 1);
            dividend = 4'd1;
            divisor  = 4'd1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d in_ready", i),  32'(in_ready),  32'd0);
            check($sformatf("bp%0d quotient", i),  32'(quotient),  32'd3);
            check($sformatf("bp%0d remainder", i), 32'(remainder), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp after hs in_ready",  32'(in_ready),  32'd1);
        check("bp after hs out_valid", 32'(out_valid), 32'd0);
        run_div(6, 3, q, r, dbz, ovf, lat);
        check("b2b 6/3 q", 32'(q), 32'd2);
        check("b2b 6/3 r", 32'(r), 32'd0);
        check("b2b 6/3 latency", 32'(lat), 32'd6);

        // Reset during the second CALC cycle of -7/3
        @(negedge clk);
        dividend = 4'b1001;
        divisor  = 4'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid-rst in_ready",  32'(in_ready),    32'd1);
        check("mid-rst out_valid", 32'(out_valid),   32'd0);
        check("mid-rst quotient",  32'(quotient),    32'd0);
        check("mid-rst remainder", 32'(remainder),   32'd0);
        check("mid-rst dbz",       32'(div_by_zero), 32'd0);
        check("mid-rst ovf",       32'(overflow),    32'd0);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1 check("aborted no result", 32'(out_valid), 32'd0);
        run_div(6, -4, q, r, dbz, ovf, lat);
        check("6/-4 q", 32'(q), 32'b1111);
        check("6/-4 r", 32'(r), 32'd2);

        // Exhaustive sweep against a signed reference model
        for (int a = -8; a < 8; a++) begin
            for (int b = -8; b < 8; b++) begin
                run_div(a, b, q, r, dbz, ovf, lat);
                if (b == 0) begin
                    eq = -1;
                    er = a;
                end else if (a == -8 && b == -1) begin
                    eq = -8;
                    er = 0;
                end else begin
                    eq = a / b;
                    er = a % b;
                end
                tq = 4'(eq);
                tr = 4'(er);
                check($sformatf("sweep %0d/%0d q", a, b),   32'(q),   32'(tq));
                check($sformatf("sweep %0d/%0d r", a, b),   32'(r),   32'(tr));
                check($sformatf("sweep %0d/%0d dbz", a, b), 32'(dbz), (b == 0) ? 32'd1 : 32'd0);
                check($sformatf("sweep %0d/%0d ovf", a, b), 32'(ovf),
                      (a == -8 && b == -1) ? 32'd1 : 32'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
